fetch_unit: RTL and testbench
=============================

# fetch_unit

Dual-slot instruction fetch stage that produces `IF_IB_PACKET[0:1]` pairs for the instruction buffer. It owns the fetch PC and issues one 64-bit aligned request at a time to instruction memory. Each returned block is split into two instruction slots, and the pair is held until the buffer accepts it. A squash redirects fetch to a new PC, and any in-flight response is discarded.

## Interface
- `RESET_PC`, default `32'h0`: fetch PC after reset. Word-aligned.
- `XLEN`, default `32`: PC and instruction width.
- `clock`, input, 1: clock.
- `reset`, input, 1: reset, synchronous, active-high.
- `squash`, input, 1: redirect request; has priority over every other event.
- `squash_pc`, input, `XLEN`: redirect target; bits [1:0] are ignored and treated as 0.
- `imem_req`, output, 1: memory request valid.
- `imem_addr`, output, `XLEN`: request address, always 8-byte aligned (bits [2:0] = 0).
- `imem_gnt`, input, 1: memory accepts the request this cycle; combinational from memory.
- `imem_rvalid`, input, 1: response data valid.
- `imem_rdata`, input, 64: [31:0] is the word at addr, [63:32] is the word at addr+4.
- `ib_full`, input, 1: instruction buffer cannot accept a write this cycle.
- `if_ib_packet[0:1]`, output, `IF_IB_PACKET`: fields `valid`, `inst`, `PC`, `NPC`; registered.

## Operation
- States:
  - REQ: `imem_req`=1.
  - WAIT: one request outstanding.
  - DRAIN: outstanding response is stale and will be discarded.
  - OUT: packet presented.
- Registers: `fetch_pc` and `state`. The packet registers hold the current pair.
- REQ: `imem_addr` = {`fetch_pc`[31:3], 3'b0}. If `imem_gnt`, go to WAIT.
- WAIT: on `imem_rvalid`, load the packet and go to OUT.
  - Aligned case (`fetch_pc`[2]=0):
    - slot0 = {1, rdata[31:0], `fetch_pc`, `fetch_pc`+4}.
    - slot1 = {1, rdata[63:32], `fetch_pc`+4, `fetch_pc`+8}.
  - Odd-word case (`fetch_pc`[2]=1):
    - slot0 = {1, rdata[63:32], `fetch_pc`, `fetch_pc`+4}.
    - slot1 = all zero.
  - Slot0 is always the valid slot, because the buffer writes on `slot0.valid` only.
- OUT: the packet is accepted on any cycle with `slot0.valid` & !`ib_full` & !`squash`. On acceptance:
  - Both slot valids clear.
  - `fetch_pc` ← {`fetch_pc`[31:3], 3'b0} + 8 (wraps modulo 2^XLEN).
  - State goes to REQ.
  - While `ib_full` is high, the packet holds unchanged.
- DRAIN: on `imem_rvalid`, drop the data and go to REQ.
- Squash, by state:
  - Every state: `fetch_pc` ← {`squash_pc`[31:2], 2'b0}, and both packet valids clear next cycle.
  - REQ with no `imem_gnt`: stay in REQ. The address changes next cycle.
  - REQ with `imem_gnt` in the same cycle: the old request is now in flight, so go to DRAIN.
  - WAIT without `imem_rvalid`: go to DRAIN.
  - WAIT with `imem_rvalid` in the same cycle: discard the data and go to REQ.
  - DRAIN: stay in DRAIN, or go to REQ if `imem_rvalid` is high that cycle.
  - OUT: go to REQ. The packet is not written, because the buffer also squashes.
- Never more than one outstanding request.

## Timing
- Reset values:
  - state = REQ, `fetch_pc` = `RESET_PC`.
  - All packet fields 0.
  - `imem_req` = 1 in the first cycle after reset deasserts.
  - `imem_addr` = `RESET_PC` & ~7.
- Outputs are Moore, decoded from state: `imem_req` = (state==REQ). Nothing combinational is driven from `squash`.
- Latency:
  - Grant at edge N, `imem_rvalid` at edge M > N.
  - Packet valid from M+1.
  - Accepted at the first edge where `ib_full`=0.
  - `imem_req` reasserts the cycle after acceptance.
- Zero-wait memory gives a minimum pair period of 3 cycles: REQ, WAIT, OUT.
- Reset mid-operation drops any outstanding response. Memory is reset together with this block.
- `imem_rvalid` while in REQ or OUT is a protocol error: ignored, flagged by an assertion.

## Structure
- `IF_IB_PACKET` lives in the shared system-definitions package, shared with the instruction buffer and ID.
- The `FETCH_STATE` enum (REQ, WAIT, DRAIN, OUT) also goes in that package, for debug visibility.
- One natural sub-module: `fetch_align`. It is combinational and maps (`fetch_pc`, `imem_rdata`) to `IF_IB_PACKET[0:1]`.
- Assertions:
  - `imem_addr`[2:0]==0.
  - `slot1.valid` implies `slot0.valid`.
  - Single outstanding request.

## Test plan
- **Reset and first fetch.** `RESET_PC`=0, zero-wait memory returning 64'h00000013_00100093, `ib_full`=0.
  - `imem_addr`=0.
  - Slot0 = {inst 00100093, PC 0, NPC 4}; slot1 = {inst 00000013, PC 4, NPC 8}.
  - Next request at addr 8.
- **Odd-word redirect.** `squash` with `squash_pc`=32'h104 while in REQ.
  - `imem_addr`=32'h100.
  - Slot0 = {rdata[63:32], PC 104, NPC 108}; slot1.valid=0.
  - Next addr 32'h108.
- **Backpressure.** Hold `ib_full`=1 for 5 cycles while in OUT.
  - Packet holds stable and `imem_req`=0.
  - Release: accepted on that edge, and `imem_req`=1 next cycle.
- **Squash in WAIT.** Response delayed 3 cycles, `squash_pc`=32'h200.
  - Stale response discarded and no packet produced.
  - Next `imem_addr`=32'h200.
- **Simultaneous events.**
  - Squash coincident with `imem_rvalid` in WAIT: no packet, next state REQ.
  - Squash in OUT with `ib_full`=0: packet valid clears, PC takes `squash_pc`.
- **Wrap-around.** Fetch at PC 32'hFFFF_FFF8, then accept.
  - Next `imem_addr`=0; slot1 NPC=0.

Source files
------------

// File: rtl/fetch_unit_pkg.sv
// Shared system definitions for the fetch -> instruction buffer -> decode path:
// the fetch/IB packet and the fetch FSM state encoding.
package fetch_unit_pkg;

    localparam int INST_W = 32;

    typedef enum logic [1:0] {
        REQ   = 2'd0,
        WAIT  = 2'd1,
        DRAIN = 2'd2,
        OUT   = 2'd3
    } FETCH_STATE;

    typedef struct packed {
        logic              valid;
        logic [INST_W-1:0] inst;
        logic [INST_W-1:0] PC;
        logic [INST_W-1:0] NPC;
    } IF_IB_PACKET;

endpackage

// File: rtl/fetch_unit_align.sv
// Splits a returned 64-bit block into the two instruction slots for the buffer.
// An odd-word fetch PC yields only slot0, carrying the upper word.
module fetch_align
    import fetch_unit_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic [XLEN-1:0] fetch_pc_i,
    input  logic [63:0]     rdata_i,
    output IF_IB_PACKET     pair_o [0:1]
);

    always_comb begin
        pair_o[0]       = '0;
        pair_o[1]       = '0;
        pair_o[0].valid = 1'b1;
        pair_o[0].PC    = fetch_pc_i;
        pair_o[0].NPC   = fetch_pc_i + XLEN'(4);
        if (!fetch_pc_i[2]) begin
            pair_o[0].inst  = rdata_i[31:0];
            pair_o[1].valid = 1'b1;
            pair_o[1].inst  = rdata_i[63:32];
            pair_o[1].PC    = fetch_pc_i + XLEN'(4);
            pair_o[1].NPC   = fetch_pc_i + XLEN'(8);
        end else begin
            pair_o[0].inst  = rdata_i[63:32];
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Dual-slot fetch stage: one aligned 64-bit request at a time, the returned pair
// is held until the instruction buffer accepts it; squash redirects and drains.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            squash,
    input  logic [XLEN-1:0] squash_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [63:0]     imem_rdata,
    input  logic            ib_full,
    output IF_IB_PACKET     if_ib_packet [0:1],
    output FETCH_STATE      state_dbg
);

    // Handshakes: a request transfers on a cycle with imem_req & imem_gnt; the
    // response is the single cycle with imem_rvalid; the packet transfers on a
    // cycle with slot0.valid & !ib_full & !squash.

    FETCH_STATE      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    IF_IB_PACKET     pkt_q [0:1];
    IF_IB_PACKET     pkt_d [0:1];
    IF_IB_PACKET     aligned [0:1];

    logic unused_squash_low;
    assign unused_squash_low = ^squash_pc[1:0];

    fetch_align #(.XLEN(XLEN)) u_align (
        .fetch_pc_i (fetch_pc_q),
        .rdata_i    (imem_rdata),
        .pair_o     (aligned)
    );

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= REQ;
            fetch_pc_q <= RESET_PC;
            pkt_q[0]   <= '0;
            pkt_q[1]   <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            pkt_q[0]   <= pkt_d[0];
            pkt_q[1]   <= pkt_d[1];
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        pkt_d[0]   = pkt_q[0];
        pkt_d[1]   = pkt_q[1];
        if (squash) begin
            // A grant or response coinciding with squash decides whether a stale
            // response is still owed, which is what DRAIN tracks.
            fetch_pc_d     = {squash_pc[XLEN-1:2], 2'b00};
            pkt_d[0].valid = 1'b0;
            pkt_d[1].valid = 1'b0;
            case (state_q)
                REQ:     state_d = imem_gnt ? DRAIN : REQ;
                WAIT:    state_d = imem_rvalid ? REQ : DRAIN;
                DRAIN:   state_d = imem_rvalid ? REQ : DRAIN;
                default: state_d = REQ;
            endcase
        end else begin
            case (state_q)
                REQ: begin
                    if (imem_gnt) state_d = WAIT;
                end
                WAIT: begin
                    if (imem_rvalid) begin
                        pkt_d[0] = aligned[0];
                        pkt_d[1] = aligned[1];
                        state_d  = OUT;
                    end
                end
                DRAIN: begin
                    if (imem_rvalid) state_d = REQ;
                end
                OUT: begin
                    if (pkt_q[0].valid && !ib_full) begin
                        pkt_d[0].valid = 1'b0;
                        pkt_d[1].valid = 1'b0;
                        fetch_pc_d     = {fetch_pc_q[XLEN-1:3], 3'b000} + XLEN'(8);
                        state_d        = REQ;
                    end
                end
                default: state_d = REQ;
            endcase
        end
    end

    always_comb begin
        imem_req        = (state_q == REQ);
        imem_addr       = {fetch_pc_q[XLEN-1:3], 3'b000};
        if_ib_packet[0] = pkt_q[0];
        if_ib_packet[1] = pkt_q[1];
        state_dbg       = state_q;
    end

    a_addr_aligned: assert property (@(posedge clock) disable iff (reset)
        imem_addr[2:0] == 3'b000);
    a_slot_order: assert property (@(posedge clock) disable iff (reset)
        pkt_q[1].valid |-> pkt_q[0].valid);
    a_single_outstanding: assert property (@(posedge clock) disable iff (reset)
        (state_q == WAIT || state_q == DRAIN) |-> !imem_req);
    a_rvalid_protocol: assert property (@(posedge clock) disable iff (reset)
        !(imem_rvalid && (state_q == REQ || state_q == OUT)));

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a latency-programmable memory model, driver tasks,
// and a monitor that pops expected grant addresses and accepted packets.
module tb_fetch_unit;
    import fetch_unit_pkg::*;

    localparam int PW = $bits(IF_IB_PACKET);
    localparam int W  = 2 * PW;

    logic        clock;
    logic        reset;
    logic        squash;
    logic [31:0] squash_pc;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid = 1'b0;
    logic [63:0] imem_rdata  = '0;
    logic        ib_full;
    IF_IB_PACKET if_ib_packet [0:1];
    FETCH_STATE  state_dbg;

    logic        gnt_en;
    int          mem_lat;
    int          n_checks = 0;
    int          n_errors = 0;

    logic [W-1:0]  exp_q[$];
    logic [31:0]   addr_q[$];

    assign imem_gnt = gnt_en & imem_req;

    fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .squash       (squash),
        .squash_pc    (squash_pc),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_gnt     (imem_gnt),
        .imem_rvalid  (imem_rvalid),
        .imem_rdata   (imem_rdata),
        .ib_full      (ib_full),
        .if_ib_packet (if_ib_packet),
        .state_dbg    (state_dbg)
    );

    // clock / reset timing: inputs change at negedge+2, memory at +1/+4, monitor at +3
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input logic [W-1:0] act);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got %0h expected nothing", name, act);
    endtask

    function automatic logic [63:0] mem_data(input logic [31:0] addr);
        if (addr == 32'h0) return 64'h00000013_00100093;
        return {(addr + 32'd4) ^ 32'h5A5A_5A5A, addr ^ 32'hA5A5_A5A5};
    endfunction

    function automatic logic [W-1:0] pair_of(input logic [31:0] pc);
        logic [63:0] d;
        IF_IB_PACKET s0;
        IF_IB_PACKET s1;
        d  = mem_data({pc[31:3], 3'b000});
        s1 = '0;
        if (!pc[2]) begin
            s0 = '{valid: 1'b1, inst: d[31:0], PC: pc, NPC: pc + 32'd4};
            s1 = '{valid: 1'b1, inst: d[63:32], PC: pc + 32'd4, NPC: pc + 32'd8};
        end else begin
            s0 = '{valid: 1'b1, inst: d[63:32], PC: pc, NPC: pc + 32'd4};
        end
        return {s0, s1};
    endfunction

    // memory model: one outstanding request, response after mem_lat idle cycles
    logic        mem_busy = 1'b0;
    int          mem_cnt  = 0;
    logic [31:0] mem_addr_r = '0;
    always @(negedge clock) begin
        #1;
        imem_rvalid = 1'b0;
        if (reset) begin
            mem_busy = 1'b0;
        end else if (mem_busy) begin
            if (mem_cnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = mem_data(mem_addr_r);
                mem_busy    = 1'b0;
            end else begin
                mem_cnt--;
            end
        end
        #3;
        if (!reset && imem_req && imem_gnt) begin
            mem_busy   = 1'b1;
            mem_cnt    = mem_lat;
            mem_addr_r = imem_addr;
        end
    end

    // monitor / scoreboard
    always @(negedge clock) begin
        #3;
        if (!reset) begin
            if (imem_req && imem_gnt) begin
                if (addr_q.size() == 0) fail_now("unexpected_grant", W'(imem_addr));
                else chk("grant_addr", W'(imem_addr), W'(addr_q.pop_front()));
            end
            if (if_ib_packet[0].valid && !ib_full && !squash) begin
                if (exp_q.size() == 0) fail_now("unexpected_packet", {if_ib_packet[0], if_ib_packet[1]});
                else chk("packet", {if_ib_packet[0], if_ib_packet[1]}, exp_q.pop_front());
            end
        end
    end

    // driver tasks
    task automatic tick();
        @(negedge clock);
        #2;
    endtask

    task automatic grant_once();
        gnt_en = 1'b1;
        tick();
        gnt_en = 1'b0;
    endtask

    task automatic wait_state(input FETCH_STATE s, input string name);
        int n;
        n = 0;
        while (state_dbg != s && n < 50) begin
            tick();
            n++;
        end
        chk(name, W'(state_dbg), W'(s));
    endtask

    initial begin
        int n;
        reset     = 1'b1;
        squash    = 1'b0;
        squash_pc = '0;
        ib_full   = 1'b0;
        gnt_en    = 1'b0;
        mem_lat   = 0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("reset_req", W'(imem_req), W'(1));
        chk("reset_addr", W'(imem_addr), W'(0));
        chk("reset_state", W'(state_dbg), W'(REQ));
        chk("reset_pkt", {if_ib_packet[0], if_ib_packet[1]}, '0);

        // first fetch, zero-wait memory
        addr_q.push_back(32'h0);
        exp_q.push_back({1'b1, 32'h00100093, 32'h0, 32'h4, 1'b1, 32'h00000013, 32'h4, 32'h8});
        grant_once();
        chk("t1_wait", W'(state_dbg), W'(WAIT));
        tick();
        chk("t1_out", W'(state_dbg), W'(OUT));
        tick();
        chk("t1_req_again", W'(imem_req), W'(1));
        chk("t1_next_addr", W'(imem_addr), W'(32'h8));

        // odd-word redirect while in REQ
        squash    = 1'b1;
        squash_pc = 32'h104;
        tick();
        squash = 1'b0;
        chk("t2_addr", W'(imem_addr), W'(32'h100));
        addr_q.push_back(32'h100);
        exp_q.push_back({1'b1, 32'h5A5A5B5E, 32'h104, 32'h108, {PW{1'b0}}});
        grant_once();
        wait_state(OUT, "t2_out");
        tick();
        chk("t2_next_addr", W'(imem_addr), W'(32'h108));

        // backpressure for five cycles in OUT
        ib_full = 1'b1;
        addr_q.push_back(32'h108);
        exp_q.push_back(pair_of(32'h108));
        grant_once();
        wait_state(OUT, "t3_out");
        for (int i = 0; i < 5; i++) begin
            chk("t3_hold", {if_ib_packet[0], if_ib_packet[1]}, pair_of(32'h108));
            chk("t3_req_low", W'(imem_req), W'(0));
            tick();
        end
        chk("t3_still_out", W'(state_dbg), W'(OUT));
        ib_full = 1'b0;
        tick();
        chk("t3_req_again", W'(imem_req), W'(1));
        chk("t3_next_addr", W'(imem_addr), W'(32'h110));

        // squash in WAIT, response delayed 3 cycles
        mem_lat = 3;
        addr_q.push_back(32'h110);
        grant_once();
        squash    = 1'b1;
        squash_pc = 32'h200;
        tick();
        squash = 1'b0;
        chk("t4_drain", W'(state_dbg), W'(DRAIN));
        chk("t4_req_low", W'(imem_req), W'(0));
        wait_state(REQ, "t4_req");
        chk("t4_no_pkt", W'(if_ib_packet[0].valid), W'(0));
        chk("t4_addr", W'(imem_addr), W'(32'h200));
        mem_lat = 0;
        addr_q.push_back(32'h200);
        exp_q.push_back(pair_of(32'h200));
        grant_once();
        wait_state(OUT, "t4_out");
        tick();
        chk("t4_next_addr", W'(imem_addr), W'(32'h208));

        // squash coincident with the response in WAIT
        mem_lat = 2;
        addr_q.push_back(32'h208);
        grant_once();
        n = 0;
        while (!imem_rvalid && n < 20) begin
            tick();
            n++;
        end
        chk("t5a_rvalid", W'(imem_rvalid), W'(1));
        chk("t5a_wait", W'(state_dbg), W'(WAIT));
        squash    = 1'b1;
        squash_pc = 32'h300;
        tick();
        squash = 1'b0;
        chk("t5a_state", W'(state_dbg), W'(REQ));
        chk("t5a_no_pkt", W'(if_ib_packet[0].valid), W'(0));
        chk("t5a_addr", W'(imem_addr), W'(32'h300));

        // squash while a packet is presented with ib_full low
        mem_lat = 0;
        addr_q.push_back(32'h300);
        grant_once();
        wait_state(OUT, "t5b_out");
        chk("t5b_valid", W'(if_ib_packet[0].valid), W'(1));
        squash    = 1'b1;
        squash_pc = 32'h404;
        tick();
        squash = 1'b0;
        chk("t5b_valid_clr", W'(if_ib_packet[0].valid), W'(0));
        chk("t5b_state", W'(state_dbg), W'(REQ));
        chk("t5b_addr", W'(imem_addr), W'(32'h400));

        // wrap-around at the top of the address space
        squash    = 1'b1;
        squash_pc = 32'hFFFF_FFF8;
        tick();
        squash = 1'b0;
        chk("t6_addr", W'(imem_addr), W'(32'hFFFF_FFF8));
        addr_q.push_back(32'hFFFF_FFF8);
        exp_q.push_back(pair_of(32'hFFFF_FFF8));
        grant_once();
        wait_state(OUT, "t6_out");
        chk("t6_slot1_npc", W'(if_ib_packet[1].NPC), W'(0));
        tick();
        chk("t6_wrap_addr", W'(imem_addr), W'(32'h0));

        tick();
        chk("leftover_packets", W'(exp_q.size()), W'(0));
        chk("leftover_grants", W'(addr_q.size()), W'(0));

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
